// File: rtl/uart_rx_frame.sv
// 8N1 serial byte receiver driven by a mid-bit baud strobe.
// Good bytes are held in a one-entry valid/ready register.
module uart_rx_frame #(
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 8192
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mosi,
   input  logic                 clk_bps,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic                 mosi_meta_q, mosi_s_q, clk_bps_d_q;
   logic                 armed_q, armed_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 strobe, deliver;

   assign strobe = clk_bps & ~clk_bps_d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mosi_meta_q <= 1'b1;
         mosi_s_q    <= 1'b1;
         clk_bps_d_q <= 1'b0;
         armed_q     <= 1'b0;
         bit_cnt_q   <= '0;
         tmo_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mosi_meta_q <= mosi;
         mosi_s_q    <= mosi_meta_q;
         clk_bps_d_q <= clk_bps;
         armed_q     <= armed_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_q       <= tmo_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_d       = tmo_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      deliver     = 1'b0;

      if (state_q == IDLE) begin
         // The line must be seen high before a falling edge counts as a start.
         tmo_d = '0;
         if (mosi_s_q) begin
            armed_d = 1'b1;
         end else if (armed_q) begin
            armed_d = 1'b0;
            state_d = START;
         end
      end else if (strobe) begin
         tmo_d = '0;
         case (state_q)
            START: begin
               if (!mosi_s_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            DATA: begin
               shift_d[bit_cnt_q] = mosi_s_q;
               bit_cnt_d          = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CW'(DATA_BITS - 1)) state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (mosi_s_q) deliver = 1'b1;
               else          frame_err_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
         tmo_d   = '0;
         state_d = IDLE;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      // A consume in the same cycle as delivery frees the slot for the new byte.
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of frames plus hand-written corner sequences.
// Bit period shortened to 16 clk with a matching short timeout.
module tb_uart_rx_frame;
   localparam int BIT = 16;
   localparam int TMO = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mosi = 1'b1;
   logic       clk_bps = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;

   int         n_vec = 0;
   int         n_err = 0;
   int         acc_cnt = 0;
   int         fe_cnt = 0;
   logic [7:0] acc_last = 8'h00;
   int         base_acc, base_fe;

   uart_rx_frame #(.DATA_BITS(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .mosi(mosi), .clk_bps(clk_bps),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Handshakes and error pulses observed mid-cycle, ahead of the edge that acts on them.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            acc_cnt  = acc_cnt + 1;
            acc_last = rx_data;
         end
         if (frame_err) fe_cnt = fe_cnt + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      mosi = b;
      repeat (BIT / 2) tick();
      clk_bps = 1'b1;
      repeat (BIT / 2) tick();
      clk_bps = 1'b0;
   endtask

   // mode 0: ready low, 1: ready high, 2: ready pulsed exactly in the stop-strobe cycle
   task automatic send_frame(input logic [7:0] d, input logic stopb, input int mode);
      send_bit(1'b0);
      for (int k = 0; k < 8; k++) send_bit(d[k]);
      mosi = stopb;
      repeat (BIT / 2) tick();
      clk_bps = 1'b1;
      if (mode == 2) rx_ready = 1'b1;
      tick();
      if (mode == 2) rx_ready = 1'b0;
      repeat (BIT / 2 - 1) tick();
      clk_bps = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stopb;
      int         mode;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ovr;
      int         exp_acc;
      int         exp_fe;
      logic [7:0] exp_last;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5, 1'b0, 1, 0, 8'hA5};
      vecs[1] = '{8'h5A, 1'b1, 0, 1'b1, 8'h5A, 1'b0, 0, 0, 8'hA5};
      vecs[2] = '{8'h96, 1'b1, 2, 1'b1, 8'h96, 1'b0, 1, 0, 8'h5A};
      vecs[3] = '{8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b0, 2, 0, 8'h00};
      vecs[4] = '{8'h3C, 1'b1, 0, 1'b1, 8'h3C, 1'b0, 0, 0, 8'h00};
      vecs[5] = '{8'hC3, 1'b1, 0, 1'b1, 8'h3C, 1'b1, 0, 0, 8'h00};

      repeat (3) tick();
      check("reset rx_data", rx_data, 8'h00);
      check("reset rx_valid", rx_valid, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      check("reset overrun", overrun, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b0;
      repeat (4) tick();

      for (int i = 0; i < 6; i++) begin
         base_acc = acc_cnt;
         base_fe  = fe_cnt;
         rx_ready = (vecs[i].mode == 1);
         send_frame(vecs[i].data, vecs[i].stopb, vecs[i].mode);
         mosi = 1'b1;
         repeat (4) tick();
         $display("vec %0d: sent %02h mode %0d -> valid=%0b data=%02h ovr=%0b busy=%0b",
                  i, vecs[i].data, vecs[i].mode, rx_valid, rx_data, overrun, busy);
         check($sformatf("v%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
         check($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_data);
         check($sformatf("v%0d overrun", i), overrun, vecs[i].exp_ovr);
         check($sformatf("v%0d accepts", i), acc_cnt - base_acc, vecs[i].exp_acc);
         check($sformatf("v%0d frame_err", i), fe_cnt - base_fe, vecs[i].exp_fe);
         check($sformatf("v%0d last byte", i), acc_last, vecs[i].exp_last);
         check($sformatf("v%0d busy", i), busy, 1'b0);
      end

      // one-cycle ready drains the held byte without touching rx_data
      base_acc = acc_cnt;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
      $display("ready pulse: valid=%0b data=%02h", rx_valid, rx_data);
      check("drain rx_valid", rx_valid, 1'b0);
      check("drain rx_data", rx_data, 8'h3C);
      check("drain accepts", acc_cnt - base_acc, 1);

      // bad stop bit, then a stuck-low line with strobes running
      base_acc = acc_cnt;
      base_fe  = fe_cnt;
      rx_ready = 1'b1;
      send_frame(8'h55, 1'b0, 1);
      repeat (3) send_bit(1'b0);
      $display("stuck low: fe=%0d valid=%0b busy=%0b", fe_cnt - base_fe, rx_valid, busy);
      check("ferr pulses", fe_cnt - base_fe, 1);
      check("ferr rx_valid", rx_valid, 1'b0);
      check("ferr accepts", acc_cnt - base_acc, 0);
      check("stuck busy", busy, 1'b0);
      mosi = 1'b1;
      repeat (4) tick();
      send_frame(8'h0F, 1'b1, 1);
      repeat (4) tick();
      $display("after ferr: last=%02h data=%02h", acc_last, rx_data);
      check("recover 0F last", acc_last, 8'h0F);
      check("recover 0F accepts", acc_cnt - base_acc, 1);

      // short low glitch on an idle line
      base_acc = acc_cnt;
      base_fe  = fe_cnt;
      mosi = 1'b0;
      repeat (4) tick();
      check("glitch busy start", busy, 1'b1);
      mosi = 1'b1;
      repeat (4) tick();
      clk_bps = 1'b1;
      repeat (BIT / 2) tick();
      clk_bps = 1'b0;
      repeat (8) tick();
      $display("glitch: busy=%0b valid=%0b fe=%0d", busy, rx_valid, fe_cnt - base_fe);
      check("glitch busy end", busy, 1'b0);
      check("glitch rx_valid", rx_valid, 1'b0);
      check("glitch frame_err", fe_cnt - base_fe, 0);
      check("glitch accepts", acc_cnt - base_acc, 0);

      // strobes stop after three data bits
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      mosi = 1'b1;
      repeat (40) tick();
      check("timeout busy before", busy, 1'b1);
      repeat (30) tick();
      $display("timeout: busy=%0b valid=%0b fe=%0d", busy, rx_valid, fe_cnt - base_fe);
      check("timeout busy after", busy, 1'b0);
      check("timeout rx_valid", rx_valid, 1'b0);
      check("timeout frame_err", fe_cnt - base_fe, 0);
      check("timeout accepts", acc_cnt - base_acc, 0);
      send_frame(8'h81, 1'b1, 1);
      repeat (4) tick();
      $display("after timeout: last=%02h", acc_last);
      check("recover 81 last", acc_last, 8'h81);
      check("recover 81 accepts", acc_cnt - base_acc, 1);

      // reset mid-frame with a held byte and overrun set
      rx_ready = 1'b0;
      send_frame(8'hAA, 1'b1, 0);
      mosi = 1'b1;
      repeat (4) tick();
      send_frame(8'hBB, 1'b1, 0);
      mosi = 1'b1;
      repeat (4) tick();
      check("pre-rst rx_valid", rx_valid, 1'b1);
      check("pre-rst rx_data", rx_data, 8'hAA);
      check("pre-rst overrun", overrun, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      rst = 1'b1;
      tick();
      $display("mid-frame rst: data=%02h valid=%0b ovr=%0b busy=%0b", rx_data, rx_valid, overrun, busy);
      check("rst rx_data", rx_data, 8'h00);
      check("rst rx_valid", rx_valid, 1'b0);
      check("rst frame_err", frame_err, 1'b0);
      check("rst overrun", overrun, 1'b0);
      check("rst busy", busy, 1'b0);
      rst  = 1'b0;
      mosi = 1'b1;
      repeat (6) tick();
      base_acc = acc_cnt;
      rx_ready = 1'b1;
      send_frame(8'hFF, 1'b1, 1);
      mosi = 1'b1;
      repeat (4) tick();
      $display("after rst: last=%02h ovr=%0b", acc_last, overrun);
      check("post-rst last", acc_last, 8'hFF);
      check("post-rst accepts", acc_cnt - base_acc, 1);
      check("post-rst overrun", overrun, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
